// File: rtl/ram_bus_if.sv
// ram_bus_if: core memory bus (Addr/Cs/We/Wdata/Rdata/Ack).
// Width macros RAM_CAPACITY and WORD_SIZE default here if not set.
`ifndef RAM_CAPACITY
`define RAM_CAPACITY 48
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 4
`endif

interface ram_bus_if;
    logic [$clog2(`RAM_CAPACITY)-1:0] Addr;
    logic                             Cs;
    logic                             We;
    logic [8*`WORD_SIZE-1:0]          Wdata;
    logic [8*`WORD_SIZE-1:0]          Rdata;
    logic                             Ack;

    modport master (
        output Addr, Cs, We, Wdata,
        input  Rdata, Ack
    );

    modport slave (
        input  Addr, Cs, We, Wdata,
        output Rdata, Ack
    );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: word RAM target with WAIT_CYCLES wait states and a one-cycle Ack.
// Define RAM_PROTECT_EN to drop writes below ROM_WORDS.
`ifndef RAM_CAPACITY
`define RAM_CAPACITY 48
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 4
`endif

module ram_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int ROM_WORDS   = 16
) (
    input logic      Clk,
    input logic      Rst_n,
    ram_bus_if.slave bus
);
    localparam int CAP = `RAM_CAPACITY;
    localparam int AW  = $clog2(CAP);
    localparam int DW  = 8 * `WORD_SIZE;
    localparam int CW  = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 ||
        ROM_WORDS < 0 || ROM_WORDS > CAP) begin : g_bad_cfg
        $error("ram_responder: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;
    logic [AW-1:0]   req_addr;
    logic            req_we;
    logic [DW-1:0]   req_wdata;
    logic [DW-1:0]   rdata_q;
    logic            ack_q;
    logic            capture;
    logic            do_access;
    logic [AW-1:0]   acc_addr;
    logic            acc_we;
    logic [DW-1:0]   acc_wdata;
    logic            in_range;
    logic            wr_ok;
    logic [DW-1:0]   mem [CAP];

    // Next state, wait counter and access strobe for the edge entering ACK
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        capture   = 1'b0;
        do_access = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.Cs) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = S_ACK;
                        do_access = 1'b1;
                    end else begin
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_d   = S_ACK;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            S_ACK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Zero-wait accesses complete on the capture edge, so use the live bus
    always_comb begin
        if (state == S_IDLE) begin
            acc_addr  = bus.Addr;
            acc_we    = bus.We;
            acc_wdata = bus.Wdata;
        end else begin
            acc_addr  = req_addr;
            acc_we    = req_we;
            acc_wdata = req_wdata;
        end
    end

    assign in_range = 32'(acc_addr) < 32'(CAP);

`ifdef RAM_PROTECT_EN
    assign wr_ok = in_range && (32'(acc_addr) >= 32'(ROM_WORDS));
`else
    assign wr_ok = in_range;
`endif

    // Control state, request registers, outputs; storage is written but never reset
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ack_q <= (state == S_ACK);
            if (capture) begin
                req_addr  <= bus.Addr;
                req_we    <= bus.We;
                req_wdata <= bus.Wdata;
            end
            if (do_access && !acc_we) begin
                rdata_q <= in_range ? mem[acc_addr] : '0;
            end
            if (do_access && acc_we && wr_ok) begin
                mem[acc_addr] <= acc_wdata;
            end
        end
    end

    assign bus.Rdata = rdata_q;
    assign bus.Ack   = ack_q;
endmodule
